// File: rtl/text_memory_arbiter.sv
// Arbitrates the single-port program text memory between instruction fetch and the
// debug/loader port, with bounded fetch priority and a one-cycle registered response.
module text_memory_arbiter #(
    parameter logic [31:0] TEXT_BEGIN    = 32'h0000_0000,
    parameter logic [31:0] TEXT_END      = 32'h0000_FFFC,
    parameter int unsigned MAX_FETCH_RUN = 4
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        fetch_req,
    input  logic [31:0] fetch_address,
    output logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    output logic        fetch_error,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [31:0] dbg_address,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ready,
    output logic        dbg_valid,
    output logic [31:0] dbg_rdata,
    output logic        dbg_error,

    output logic [13:0] mem_address,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_q
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_FETCH_RUN);

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_FETCH,
        RESP_DBG
    } resp_t;

    // Offset form keeps the range test a single unsigned compare even when TEXT_BEGIN is 0.
    function automatic logic is_legal(input logic [31:0] addr);
        return ((addr - TEXT_BEGIN) <= (TEXT_END - TEXT_BEGIN)) && (addr[1:0] == 2'b00);
    endfunction

    logic [3:0] run_cnt;
    logic       fetch_legal;
    logic       dbg_legal;

    resp_t      resp_p1;
    logic       illegal_p1;
    logic       write_p1;

    // ---- stage 0: grant and memory request ----
    assign fetch_legal = is_legal(fetch_address);
    assign dbg_legal   = is_legal(dbg_address);

    assign fetch_ready = fetch_req && !(dbg_req && (run_cnt == RUN_MAX));
    assign dbg_ready   = dbg_req && !fetch_ready;

    assign mem_address = dbg_ready ? dbg_address[15:2] : fetch_address[15:2];
    assign mem_we      = reset_n && dbg_ready && dbg_we && dbg_legal;
    assign mem_wdata   = dbg_wdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            resp_p1    <= RESP_NONE;
            illegal_p1 <= 1'b0;
            write_p1   <= 1'b0;
            run_cnt    <= 4'd0;
        end else begin
            if (fetch_ready) begin
                resp_p1    <= RESP_FETCH;
                illegal_p1 <= !fetch_legal;
                write_p1   <= 1'b0;
            end else if (dbg_ready) begin
                resp_p1    <= RESP_DBG;
                illegal_p1 <= !dbg_legal;
                write_p1   <= dbg_we;
            end else begin
                resp_p1    <= RESP_NONE;
                illegal_p1 <= 1'b0;
                write_p1   <= 1'b0;
            end

            if (!dbg_req || dbg_ready) begin
                run_cnt <= 4'd0;
            end else if (fetch_ready && (run_cnt != RUN_MAX)) begin
                run_cnt <= run_cnt + 4'd1;
            end
        end
    end

    // ---- stage 1: response, memory data arrives one cycle after the grant ----
    assign fetch_valid = (resp_p1 == RESP_FETCH);
    assign fetch_error = fetch_valid && illegal_p1;
    assign fetch_data  = (fetch_valid && !illegal_p1) ? mem_q : 32'd0;

    assign dbg_valid   = (resp_p1 == RESP_DBG);
    assign dbg_error   = dbg_valid && illegal_p1;
    assign dbg_rdata   = (dbg_valid && !illegal_p1 && !write_p1) ? mem_q : 32'd0;

endmodule

// File: tb/tb_text_memory_arbiter.sv
// Bench for text_memory_arbiter: behavioral text memory, vector table for grants and
// memory-side outputs, and a response scoreboard fed from a reference memory image.
module tb_text_memory_arbiter;

    logic        clock;
    logic        reset_n;
    logic        fetch_req;
    logic [31:0] fetch_address;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        fetch_error;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_address;
    logic [31:0] dbg_wdata;
    logic        dbg_ready;
    logic        dbg_valid;
    logic [31:0] dbg_rdata;
    logic        dbg_error;
    logic [13:0] mem_address;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_q;

    text_memory_arbiter #(
        .TEXT_BEGIN    (32'h0000_0000),
        .TEXT_END      (32'h0000_FFFC),
        .MAX_FETCH_RUN (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .fetch_req     (fetch_req),
        .fetch_address (fetch_address),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .fetch_data    (fetch_data),
        .fetch_error   (fetch_error),
        .dbg_req       (dbg_req),
        .dbg_we        (dbg_we),
        .dbg_address   (dbg_address),
        .dbg_wdata     (dbg_wdata),
        .dbg_ready     (dbg_ready),
        .dbg_valid     (dbg_valid),
        .dbg_rdata     (dbg_rdata),
        .dbg_error     (dbg_error),
        .mem_address   (mem_address),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_q         (mem_q)
    );

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_fr;
        logic        exp_dr;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic        is_dbg;
        logic [31:0] data;
        logic        err;
    } exp_resp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [0:16383];
    logic [31:0] tmem    [0:16383];
    exp_resp_t   sb [$];
    vec_t        vecs [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5A5_0000 | 32'(i);
    endfunction

    // Synchronous single-port text memory, read data registered one cycle.
    initial begin
        for (int i = 0; i < 16384; i++) tmem[i] = init_word(i);
        mem_q = 32'd0;
        forever begin
            @(posedge clock);
            if (mem_we) tmem[mem_address] <= mem_wdata;
            mem_q <= tmem[mem_address];
        end
    end

    function automatic logic legal(input logic [31:0] a);
        return (a <= 32'h0000_FFFC) && (a[1:0] == 2'b00);
    endfunction

    function automatic vec_t mk(input logic fr, input logic [31:0] fa, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic efr, input logic edr, input logic ewe);
        vec_t v;
        v.f_req = fr; v.f_addr = fa; v.d_req = dr; v.d_we = dw; v.d_addr = da;
        v.d_wdata = dd; v.exp_fr = efr; v.exp_dr = edr; v.exp_we = ewe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_resp();
        exp_resp_t   e;
        logic        fv, dv, fe, de;
        logic [31:0] fd, dd;
        fv = 0; dv = 0; fe = 0; de = 0; fd = 0; dd = 0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.is_dbg) begin
                dv = 1; dd = e.data; de = e.err;
            end else begin
                fv = 1; fd = e.data; fe = e.err;
            end
        end
        chk("fetch_valid", 32'(fetch_valid), 32'(fv));
        chk("fetch_data",  fetch_data,       fd);
        chk("fetch_error", 32'(fetch_error), 32'(fe));
        chk("dbg_valid",   32'(dbg_valid),   32'(dv));
        chk("dbg_rdata",   dbg_rdata,        dd);
        chk("dbg_error",   32'(dbg_error),   32'(de));
    endtask

    task automatic step(input vec_t v);
        exp_resp_t   e;
        logic [13:0] idx;
        logic        lg;
        @(posedge clock);
        #1;
        fetch_req = v.f_req; fetch_address = v.f_addr;
        dbg_req = v.d_req; dbg_we = v.d_we; dbg_address = v.d_addr; dbg_wdata = v.d_wdata;
        @(negedge clock);
        cyc++;
        check_resp();
        chk("fetch_ready", 32'(fetch_ready), 32'(v.exp_fr));
        chk("dbg_ready",   32'(dbg_ready),   32'(v.exp_dr));
        chk("mem_we",      32'(mem_we),      32'(v.exp_we));
        idx = v.exp_dr ? v.d_addr[15:2] : v.f_addr[15:2];
        chk("mem_address", 32'(mem_address), 32'(idx));
        if (v.exp_we) chk("mem_wdata", mem_wdata, v.d_wdata);
        if (v.exp_fr) begin
            lg = legal(v.f_addr);
            e.is_dbg = 0; e.err = !lg; e.data = lg ? ref_mem[v.f_addr[15:2]] : 32'd0;
            sb.push_back(e);
        end
        if (v.exp_dr) begin
            lg = legal(v.d_addr);
            e.is_dbg = 1; e.err = !lg;
            e.data = (lg && !v.d_we) ? ref_mem[v.d_addr[15:2]] : 32'd0;
            sb.push_back(e);
            if (lg && v.d_we) ref_mem[v.d_addr[15:2]] = v.d_wdata;
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);

        // fr fa            dr dw da            dd             efr edr ewe
        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0004, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0008, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0,        32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 1, 1, 32'h100,      32'hDEADBEEF,  0, 1, 1));
        vecs.push_back(mk(1, 32'h0000_0100, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0,        32'h0,         0, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 1, 0, 32'h100,      32'h0,         0, 1, 0));
        // fetch held while a debug read waits: four fetch grants, then debug
        vecs.push_back(mk(1, 32'h0000_000C, 1, 0, 32'h8,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0010, 1, 0, 32'h8,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0014, 1, 0, 32'h8,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0018, 1, 0, 32'h8,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_001C, 1, 0, 32'h8,        32'h0,         0, 1, 0));
        vecs.push_back(mk(1, 32'h0000_001C, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        // illegal accesses, all aliasing word 0
        vecs.push_back(mk(1, 32'h0001_0000, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 1, 1, 32'h2,        32'h0000_0055, 0, 1, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 1, 0, 32'h0001_0000, 32'h0,        0, 1, 0));
        vecs.push_back(mk(1, 32'h0000_0000, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        // top word of the text range
        vecs.push_back(mk(0, 32'h0000_0000, 1, 1, 32'hFFFC,     32'hCAFEF00D,  0, 1, 1));
        vecs.push_back(mk(1, 32'h0000_FFFC, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0004, 1, 0, 32'h4,        32'h0,         1, 0, 0));
        vecs.push_back(mk(1, 32'h0000_0004, 1, 0, 32'h4,        32'h0,         1, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 1, 0, 32'h4,        32'h0,         0, 1, 0));
        vecs.push_back(mk(1, 32'h0000_0006, 0, 0, 32'h0,        32'h0,         1, 0, 0));
        vecs.push_back(mk(0, 32'h0000_0000, 0, 0, 32'h0,        32'h0,         0, 0, 0));

        // Reset state: fetch held so memory read data is nonzero but must stay hidden.
        reset_n = 1'b0;
        fetch_req = 1'b1; fetch_address = 32'h4;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_address = 32'h0; dbg_wdata = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_resp();
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_mem_address", 32'(mem_address), 32'd1);
        chk("rst_mem_we",      32'(mem_we),      32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1; fetch_req = 1'b0;

        foreach (vecs[i]) step(vecs[i]);

        // Reset pulse while a fetch response is in flight.
        step(mk(1, 32'h0000_0008, 0, 0, 32'h0, 32'h0, 1, 0, 0));
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        fetch_req = 1'b0; dbg_req = 1'b1; dbg_we = 1'b1;
        dbg_address = 32'h20; dbg_wdata = 32'h1234_5678;
        @(negedge clock);
        cyc++;
        chk("rstmid_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rstmid_fetch_data",  fetch_data,       32'd0);
        chk("rstmid_fetch_error", 32'(fetch_error), 32'd0);
        chk("rstmid_dbg_valid",   32'(dbg_valid),   32'd0);
        chk("rstmid_dbg_ready",   32'(dbg_ready),   32'd1);
        chk("rstmid_mem_we",      32'(mem_we),      32'd0);
        sb.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1; dbg_req = 1'b0; dbg_we = 1'b0;
        @(negedge clock);
        cyc++;
        check_resp();
        step(mk(1, 32'h0000_0020, 0, 0, 32'h0, 32'h0, 1, 0, 0));
        step(mk(0, 32'h0000_0000, 1, 0, 32'h8, 32'h0, 0, 1, 0));
        step(mk(0, 32'h0000_0000, 0, 0, 32'h0, 32'h0, 0, 0, 0));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
